seg7_spi_sequencer: RTL and testbench
=====================================

// Module: seg7_spi_sequencer
// PURPOSE
//  Upstream feeder for the SPI master on the 74HC595 display chain (slave select SS1).
//  Accepts a 32-bit value and a decimal-point mask, and converts each nibble to a 7-segment code.
//  Pushes the 8 code bytes to the SPI master one byte at a time, then closes the frame so the SS rising edge latches the 595s.
//  Flash/MPU readback data reaches the HEX displays through this block.
// PARAMETERS
//  NUM_DIGITS      8  number of chained 74HC595/digits, one byte each
//  SEG_ACTIVE_LOW  0  1 = invert segment byte (common-anode digits)
//  GAP_CYCLES      4  clk_i cycles spi_ss_o is held high after a frame (latch pulse width)
// PORTS
//  clk_i            in   1   base clock
//  rst_i            in   1   asynchronous reset, active-low
//  value_i          in   32  hex value; value_i[31:28] = leftmost digit (digit 7)
//  dp_i             in   8   decimal-point mask, dp_i[k] lights digit k
//  value_valid_i    in   1   request; accepted when value_valid_i & ready_o
//  ready_o          out  1   high only in IDLE
//  spi_tx_data_o    out  8   byte offered to the SPI master
//  spi_tx_valid_o   out  1   byte offer; held stable until spi_tx_ready_i
//  spi_tx_ready_i   in   1   SPI master takes the byte this cycle
//  spi_done_i       in   1   1-cycle pulse: offered byte fully shifted out
//  spi_ss_o         out  1   frame select to the 595 chain, active-low
//  frame_done_o     out  1   1-cycle pulse after the latch gap ends
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - spi_ss_o=1, spi_tx_valid_o=0, spi_tx_data_o=0, ready_o=0, frame_done_o=0.
//   - FSM goes to IDLE. ready_o rises on the first clock after release.
//  Segment byte layout is {dp,g,f,e,d,c,b,a}, active-high hex codes:
//   0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
//   The dp bit is OR'd in; the whole byte is inverted when SEG_ACTIVE_LOW=1.
//  Byte order: digit NUM_DIGITS-1 first, digit 0 last. Each byte goes out MSB first (done by the master).
//  FSM states: IDLE, OFFER, SHIFT, GAP, DONE.
//   IDLE : ready_o=1. On value_valid_i, latch value_i/dp_i into a shadow reg, set digit_cnt=NUM_DIGITS-1,
//          drive spi_ss_o=0 -> OFFER.
//   OFFER: spi_tx_valid_o=1 with the code for digit_cnt. On spi_tx_ready_i -> SHIFT (valid drops the next cycle).
//   SHIFT: wait for spi_done_i. If digit_cnt==0 -> GAP and spi_ss_o=1; else decrement digit_cnt -> OFFER.
//   GAP  : count GAP_CYCLES with spi_ss_o=1 -> DONE.
//   DONE : frame_done_o=1 for exactly one cycle -> IDLE.
//  Timing: accept in cycle N; spi_ss_o low and first offer at N+1. No gaps beyond handshake stalls.
//  spi_ss_o stays low continuously from the first offer to the last spi_done_i. It never toggles mid-frame.
//  Boundary conditions:
//   - value_valid_i outside IDLE is ignored; the shadow reg is not updated mid-frame.
//   - spi_done_i seen in IDLE, OFFER, GAP or DONE is ignored.
//   - spi_tx_ready_i and spi_done_i in the same cycle in OFFER: take ready only; done must come later.
//   - Reset mid-frame: spi_ss_o goes high immediately and spi_tx_valid_o low immediately. No partial latch is retried.
//   - digit_cnt is $clog2(NUM_DIGITS) wide, decrements only in SHIFT, and never wraps below 0.
//   - GAP counter is $clog2(GAP_CYCLES+1) wide. GAP_CYCLES=0 is illegal and is flagged by an elaboration assertion.
// STRUCTURE
//  spi_pkg (shared with spi_master):
//   - seq_state_t enum {IDLE,OFFER,SHIFT,GAP,DONE}
//   - SEG_HEX[16] localparam table, SEG_DP_BIT=7
//  Sub-module hex_to_seg7: combinational, nibble+dp+invert -> 8-bit code.
//   Instantiated once and fed by a nibble mux on digit_cnt.
//  The top holds the FSM, shadow regs, digit/gap counters and output regs. All outputs are registered.
// TESTING
//  1. value=32'h1234ABCD, dp=0, ACTIVE_LOW=0, master model ready=1 and done 8 clk later
//     -> bytes 06,5B,4F,66,77,7C,39,5E; ss low across all 8; frame_done 1 pulse.
//  2. Same value with SEG_ACTIVE_LOW=1, dp=8'h81 -> bytes 79,A4,B0,99,88,83,C6,21.
//  3. Hold spi_tx_ready_i low 5 cycles on byte 3 -> data and valid stable throughout; order and count unchanged.
//  4. Pulse value_valid_i with 32'hFFFFFFFF mid-frame of 32'h0 -> ignored;
//     all 8 bytes=3F; a second frame starts only after frame_done.
//  5. Assert rst_i low during byte 5 -> ss=1 and valid=0 the same cycle; next request sends a full 8-byte frame.
//  6. Stray spi_done_i in IDLE and GAP -> no state change; GAP lasts exactly GAP_CYCLES cycles with ss=1.

Source files
------------

// File: rtl/seg7_spi_sequencer_pkg.sv
// Shared types and segment table for the 7-segment SPI display path.
package seg7_spi_sequencer_pkg;

  typedef enum logic [2:0] {IDLE, OFFER, SHIFT, GAP, DONE} seq_state_t;

  localparam int SEG_DP_BIT = 7;

  // {dp,g,f,e,d,c,b,a}, active-high, dp clear
  localparam logic [7:0] SEG_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

endpackage

// File: rtl/seg7_spi_sequencer_if.sv
// Value request and SPI-master byte handshake for the display sequencer.
interface seg7_spi_sequencer_if #(parameter int NUM_DIGITS = 8);
  logic [4*NUM_DIGITS-1:0] value_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic                    value_valid_i;
  logic                    ready_o;
  logic [7:0]              spi_tx_data_o;
  logic                    spi_tx_valid_o;
  logic                    spi_tx_ready_i;
  logic                    spi_done_i;
  logic                    spi_ss_o;
  logic                    frame_done_o;

  modport master (
    input  value_i, dp_i, value_valid_i, spi_tx_ready_i, spi_done_i,
    output ready_o, spi_tx_data_o, spi_tx_valid_o, spi_ss_o, frame_done_o
  );

  modport slave (
    output value_i, dp_i, value_valid_i, spi_tx_ready_i, spi_done_i,
    input  ready_o, spi_tx_data_o, spi_tx_valid_o, spi_ss_o, frame_done_o
  );
endinterface

// File: rtl/seg7_spi_sequencer_hex_to_seg7.sv
// Nibble to 7-segment byte, with decimal point and optional inversion.
module hex_to_seg7
  import seg7_spi_sequencer_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       invert,
  output logic [7:0] code
);
  logic [7:0] raw;

  assign raw  = SEG_HEX[nibble] | (8'(dp) << SEG_DP_BIT);
  assign code = invert ? ~raw : raw;
endmodule

// File: rtl/seg7_spi_sequencer.sv
// Feeds 7-segment code bytes for a hex value to the SPI master and frames
// them with slave select so the rising edge latches the 74HC595 chain.
module seg7_spi_sequencer
  import seg7_spi_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int GAP_CYCLES     = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  seg7_spi_sequencer_if.master bus
);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1) begin : g_gap_chk
    $error("seg7_spi_sequencer: GAP_CYCLES must be at least 1");
  end

  seq_state_t              state;
  logic [VAL_W-1:0]        shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [DIG_W-1:0]        digit_cnt;
  logic [GAP_W-1:0]        gap_cnt;

  logic [VAL_W-1:0]        src_val;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [DIG_W-1:0]        sel;
  logic [3:0]              nib;
  logic                    nib_dp;
  logic [7:0]              code;

  // The encoder looks one byte ahead so the offer register loads on the same
  // edge that accepts a request or sees spi_done: raw inputs in IDLE, shadow after.
  always_comb begin
    src_val = shadow_val;
    src_dp  = shadow_dp;
    sel     = digit_cnt - DIG_W'(1);
    if (state == IDLE) begin
      src_val = bus.value_i;
      src_dp  = bus.dp_i;
      sel     = LAST_DIG;
    end
    nib    = '0;
    nib_dp = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel == DIG_W'(k)) begin
        nib    = src_val[4*k +: 4];
        nib_dp = src_dp[k];
      end
    end
  end

  hex_to_seg7 u_seg (
    .nibble (nib),
    .dp     (nib_dp),
    .invert (SEG_ACTIVE_LOW),
    .code   (code)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state              <= IDLE;
      shadow_val         <= '0;
      shadow_dp          <= '0;
      digit_cnt          <= '0;
      gap_cnt            <= '0;
      bus.ready_o        <= 1'b0;
      bus.spi_ss_o       <= 1'b1;
      bus.spi_tx_valid_o <= 1'b0;
      bus.spi_tx_data_o  <= '0;
      bus.frame_done_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.value_valid_i && bus.ready_o) begin
            shadow_val         <= bus.value_i;
            shadow_dp          <= bus.dp_i;
            digit_cnt          <= LAST_DIG;
            bus.ready_o        <= 1'b0;
            bus.spi_ss_o       <= 1'b0;
            bus.spi_tx_valid_o <= 1'b1;
            bus.spi_tx_data_o  <= code;
            state              <= OFFER;
          end else begin
            bus.ready_o <= 1'b1;
          end
        end
        OFFER: begin
          // spi_done here belongs to no byte of ours yet; only ready matters
          if (bus.spi_tx_ready_i) begin
            bus.spi_tx_valid_o <= 1'b0;
            state              <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.spi_done_i) begin
            if (digit_cnt == '0) begin
              bus.spi_ss_o <= 1'b1;
              gap_cnt      <= '0;
              state        <= GAP;
            end else begin
              digit_cnt          <= digit_cnt - DIG_W'(1);
              bus.spi_tx_valid_o <= 1'b1;
              bus.spi_tx_data_o  <= code;
              state              <= OFFER;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_END) begin
            bus.frame_done_o <= 1'b1;
            state            <= DONE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        DONE: begin
          bus.frame_done_o <= 1'b0;
          bus.ready_o      <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg7_spi_sequencer.sv
// Directed bench: active-high and active-low sequencers driven side by side
// by one SPI master model.
module tb_seg7_spi_sequencer;
  localparam int ND  = 8;
  localparam int GAP = 4;
  localparam int DLY = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] value = '0;
  logic [7:0]  dp = '0;
  logic        vv = 1'b0;
  logic        rdy = 1'b1;
  logic        mdone = 1'b0;
  logic        stray = 1'b0;
  logic        stray_idle = 1'b0;

  seg7_spi_sequencer_if #(.NUM_DIGITS(ND)) b0();
  seg7_spi_sequencer_if #(.NUM_DIGITS(ND)) b1();

  assign b0.value_i        = value;
  assign b0.dp_i           = dp;
  assign b0.value_valid_i  = vv;
  assign b0.spi_tx_ready_i = rdy;
  assign b0.spi_done_i     = mdone | stray | stray_idle;
  assign b1.value_i        = value;
  assign b1.dp_i           = dp;
  assign b1.value_valid_i  = vv;
  assign b1.spi_tx_ready_i = rdy;
  assign b1.spi_done_i     = mdone | stray | stray_idle;

  seg7_spi_sequencer #(.NUM_DIGITS(ND), .SEG_ACTIVE_LOW(1'b0), .GAP_CYCLES(GAP)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .bus(b0));
  seg7_spi_sequencer #(.NUM_DIGITS(ND), .SEG_ACTIVE_LOW(1'b1), .GAP_CYCLES(GAP)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .bus(b1));

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int mcnt = 0, rises = 0, fd_cnt = 0, gap_len = 0, ss_bad = 0;
  int stall_idx = -1, stall_left = 0, stall_seen = 0, stab_bad = 0;
  bit in_gap = 1'b0, prev_ss = 1'b1, gap_stray_req = 1'b0;
  logic [7:0] stall_data = '0;

  // SPI master model and frame monitor; decisions made here apply at the next posedge
  always @(negedge clk) begin
    mdone = 1'b0;
    stray = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) mdone = 1'b1;
      end
      if (b0.spi_tx_valid_o && b0.spi_ss_o) ss_bad++;
      rdy = 1'b1;
      if (b0.spi_tx_valid_o && q0.size() == stall_idx && stall_left > 0) begin
        if (stall_seen == 0) stall_data = b0.spi_tx_data_o;
        else if (b0.spi_tx_data_o !== stall_data) stab_bad++;
        rdy = 1'b0;
        stall_left--;
        stall_seen++;
      end
      if (b0.spi_tx_valid_o && rdy) begin
        q0.push_back(b0.spi_tx_data_o);
        if (b1.spi_tx_valid_o) q1.push_back(b1.spi_tx_data_o);
        mcnt = DLY;
      end
    end
    if (!prev_ss && b0.spi_ss_o) begin
      in_gap = 1'b1;
      gap_len = 0;
      rises++;
    end
    if (!b0.spi_ss_o) in_gap = 1'b0;
    if (in_gap) begin
      if (b0.frame_done_o) in_gap = 1'b0;
      else begin
        gap_len++;
        if (gap_stray_req && gap_len == 2) begin
          stray = 1'b1;
          gap_stray_req = 1'b0;
        end
      end
    end
    if (b0.frame_done_o) fd_cnt++;
    prev_ss = b0.spi_ss_o;
  end

  task automatic clear_mon();
    q0.delete();
    q1.delete();
    rises = 0; fd_cnt = 0; gap_len = 0; ss_bad = 0;
    stall_seen = 0; stab_bad = 0;
  endtask

  task automatic start_frame(input logic [31:0] v, input logic [7:0] d);
    @(negedge clk);
    value = v; dp = d; vv = 1'b1;
    @(negedge clk);
    vv = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (b0.frame_done_o) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: frame_done_o never seen within 400 cycles, expected 1", name);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({b0.spi_ss_o, b0.spi_tx_valid_o, b0.ready_o, b0.frame_done_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: ss,valid,ready,fd=%b expected 1000",
               {b0.spi_ss_o, b0.spi_tx_valid_o, b0.ready_o, b0.frame_done_o});
    end
    checks++;
    if (b0.spi_tx_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", b0.spi_tx_data_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (b0.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_clk: got %b expected 0", b0.ready_o);
    end
    @(negedge clk);
    checks++;
    if (b0.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after_clk: got %b expected 1", b0.ready_o);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h77, 8'h7C, 8'h39, 8'h5E};
    clear_mon();
    start_frame(32'h1234ABCD, 8'h00);
    checks++;
    if ({b0.spi_ss_o, b0.spi_tx_valid_o, b0.ready_o} !== 3'b010 || b0.spi_tx_data_o !== 8'h06) begin
      errors++;
      $display("FAIL basic_first_offer: ss,valid,ready=%b data=%h expected 010 data=06",
               {b0.spi_ss_o, b0.spi_tx_valid_o, b0.ready_o}, b0.spi_tx_data_o);
    end
    wait_frame("basic");
    checks++;
    if (b0.frame_done_o !== 1'b0 || b0.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_done: fd=%b ready=%b expected fd=0 ready=1", b0.frame_done_o, b0.ready_o);
    end
    @(negedge clk);
    checks++;
    if (q0.size() !== 8) begin
      errors++;
      $display("FAIL basic_count: got %0d bytes expected 8", q0.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q0[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h expected %h", i, q0[i], exp[i]);
      end
    end
    checks++;
    if (rises !== 1 || fd_cnt !== 1 || ss_bad !== 0) begin
      errors++;
      $display("FAIL basic_framing: ss_rises=%0d fd_pulses=%0d offers_with_ss_high=%0d expected 1 1 0",
               rises, fd_cnt, ss_bad);
    end
    checks++;
    if (gap_len !== GAP) begin
      errors++;
      $display("FAIL basic_gap: got %0d cycles expected %0d", gap_len, GAP);
    end
  endtask

  task automatic test_active_low();
    logic [7:0] exp1 [8] = '{8'h79, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hC6, 8'h21};
    logic [7:0] exp0 [8] = '{8'h86, 8'h5B, 8'h4F, 8'h66, 8'h77, 8'h7C, 8'h39, 8'hDE};
    clear_mon();
    start_frame(32'h1234ABCD, 8'h81);
    wait_frame("active_low");
    @(negedge clk);
    checks++;
    if (q1.size() !== 8 || q0.size() !== 8) begin
      errors++;
      $display("FAIL active_low_count: got %0d/%0d bytes expected 8/8", q1.size(), q0.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q1[i] !== exp1[i] || q0[i] !== exp0[i]) begin
        errors++;
        $display("FAIL active_low_byte%0d: got %h/%h expected %h/%h", i, q1[i], q0[i], exp1[i], exp0[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [8] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h77, 8'h7C, 8'h39, 8'h5E};
    clear_mon();
    stall_idx = 3;
    stall_left = 5;
    start_frame(32'h1234ABCD, 8'h00);
    wait_frame("stall");
    @(negedge clk);
    stall_idx = -1;
    checks++;
    if (stall_seen !== 5 || stab_bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: valid cycles stalled=%0d unstable=%0d expected 5 0", stall_seen, stab_bad);
    end
    checks++;
    if (q0.size() !== 8 || rises !== 1) begin
      errors++;
      $display("FAIL stall_count: bytes=%0d ss_rises=%0d expected 8 1", q0.size(), rises);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q0[i] !== exp[i]) begin
        errors++;
        $display("FAIL stall_byte%0d: got %h expected %h", i, q0[i], exp[i]);
      end
    end
  endtask

  task automatic test_ignore_midframe();
    int n;
    clear_mon();
    start_frame(32'h0000_0000, 8'h00);
    for (n = 0; n < 300 && q0.size() < 3; n++) @(negedge clk);
    checks++;
    if (n == 300) begin
      errors++;
      $display("FAIL ignore_progress: got %0d bytes expected 3", q0.size());
    end
    value = 32'hFFFF_FFFF; dp = 8'hFF; vv = 1'b1;
    checks++;
    if (b0.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_ready: got %b expected 0", b0.ready_o);
    end
    @(negedge clk);
    vv = 1'b0;
    wait_frame("ignore");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q0[i] !== 8'h3F) begin
        errors++;
        $display("FAIL ignore_byte%0d: got %h expected 3f", i, q0[i]);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (q0.size() !== 8 || b0.spi_ss_o !== 1'b1 || fd_cnt !== 1) begin
      errors++;
      $display("FAIL ignore_no_second_frame: bytes=%0d ss=%b fd=%0d expected 8 1 1",
               q0.size(), b0.spi_ss_o, fd_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    logic [7:0] exp [8] = '{8'h3F, 8'h71, 8'h06, 8'hF9, 8'h5B, 8'h5E, 8'h4F, 8'h39};
    clear_mon();
    stall_idx = 5;
    stall_left = 20;
    start_frame(32'h1234ABCD, 8'h00);
    for (n = 0; n < 300 && stall_seen < 2; n++) @(negedge clk);
    checks++;
    if (n == 300) begin
      errors++;
      $display("FAIL rst_mid_progress: stalled cycles=%0d expected 2", stall_seen);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b0.spi_ss_o !== 1'b1 || b0.spi_tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_immediate: ss=%b valid=%b expected 1 0", b0.spi_ss_o, b0.spi_tx_valid_o);
    end
    stall_left = 0;
    stall_idx = -1;
    mcnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (b0.ready_o !== 1'b1 || b0.spi_ss_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_idle: ready=%b ss=%b expected 1 1", b0.ready_o, b0.spi_ss_o);
    end
    clear_mon();
    start_frame(32'h0F1E2D3C, 8'h10);
    wait_frame("rst_mid");
    @(negedge clk);
    checks++;
    if (q0.size() !== 8 || rises !== 1 || fd_cnt !== 1) begin
      errors++;
      $display("FAIL rst_mid_refill: bytes=%0d ss_rises=%0d fd=%0d expected 8 1 1", q0.size(), rises, fd_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q0[i] !== exp[i]) begin
        errors++;
        $display("FAIL rst_mid_byte%0d: got %h expected %h", i, q0[i], exp[i]);
      end
    end
  endtask

  task automatic test_stray_done();
    @(negedge clk);
    stray_idle = 1'b1;
    @(negedge clk);
    stray_idle = 1'b0;
    @(negedge clk);
    checks++;
    if ({b0.ready_o, b0.spi_ss_o, b0.spi_tx_valid_o, b0.frame_done_o} !== 4'b1100) begin
      errors++;
      $display("FAIL stray_idle: ready,ss,valid,fd=%b expected 1100",
               {b0.ready_o, b0.spi_ss_o, b0.spi_tx_valid_o, b0.frame_done_o});
    end
    clear_mon();
    gap_stray_req = 1'b1;
    start_frame(32'h1234ABCD, 8'h00);
    wait_frame("stray_gap");
    @(negedge clk);
    checks++;
    if (gap_len !== GAP || fd_cnt !== 1 || rises !== 1) begin
      errors++;
      $display("FAIL stray_gap: gap=%0d fd=%0d ss_rises=%0d expected %0d 1 1", gap_len, fd_cnt, rises, GAP);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_active_low();
    test_stall();
    test_ignore_midframe();
    test_reset_midframe();
    test_stray_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
